// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, one start bit and one stop bit.
// Defining UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       ret,
    input  logic       wr,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // state  | meaning
    // IDLE   | line high, waiting for wr
    // START  | start bit (0)
    // DATA   | data bits, index 0..7, LSB first
    // PARITY | even-parity bit (only reachable with UART_TX_PARITY_EN)
    // STOP   | stop bit (1); a new request may be taken on its last edge
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        tx_d, busy_d, done_d;
    logic        baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge ret) begin
        if (!ret) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx      <= tx_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // tx/busy/done are registered, so each transition sets the value for the next state
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        idx_d   = idx_q;
        data_d  = data_q;
        tx_d    = tx;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                idx_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (wr) begin
                    state_d = START;
                    data_d  = data_in;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (baud_end) begin
                    state_d = STOP;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    done_d = 1'b1;
                    if (wr) begin
                        state_d = START;
                        data_d  = data_in;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: two instances (4 and 2 clocks per bit),
// stimulus pushes expected frames, per-instance monitors check the serial line.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       ret;
    logic       wr_a, wr_b;
    logic [7:0] data_a, data_b;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .ret(ret), .wr(wr_a), .data_in(data_a),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    uart_tx #(.CLKS_PER_BIT(2)) dut_b (
        .clk(clk), .ret(ret), .wr(wr_b), .data_in(data_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       abort;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   idle_done_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = p;
`else
        f[9]   = 1'b1;
        f[10]  = p | 1'b1;
`endif
        return f;
    endfunction

    task automatic sample(input int m, output logic t, output logic b, output logic d);
        if (m == 0) begin t = tx_a; b = busy_a; d = done_a; end
        else        begin t = tx_b; b = busy_b; d = done_b; end
    endtask

    task automatic monitor(input int m);
        int cpb, bad_tx, bad_busy, bad_done, first_bad;
        logic t, b, d;
        bit carry, aborted;
        exp_t e;
        logic [10:0] fb;
        cpb   = (m == 0) ? 4 : 2;
        carry = 0;
        forever begin
            if (!carry) begin
                @(negedge clk);
                sample(m, t, b, d);
                if (!ret) continue;
                if (d) idle_done_err++;
                if (t) continue;
            end
            carry = 0;
            if (m == 0 && q_a.size() > 0)      e = q_a.pop_front();
            else if (m == 1 && q_b.size() > 0) e = q_b.pop_front();
            else begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame dut%0d: frame started with no request pending", m);
                e = '0;
            end
            fb = frame_bits(e.data, e.par);
            bad_tx = 0; bad_busy = 0; bad_done = 0; first_bad = -1; aborted = 0;
            for (int k = 0; k < NB * cpb; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    sample(m, t, b, d);
                end
                if (!ret) begin aborted = 1; break; end
                if (t !== fb[k / cpb]) begin
                    bad_tx++;
                    if (first_bad < 0) first_bad = k;
                end
                if (b !== 1'b1) bad_busy++;
                if (k > 0 && d !== 1'b0) bad_done++;
            end
            if (aborted) begin
                check($sformatf("abort_expected dut%0d data %0h", m, e.data), e.abort, 1);
                continue;
            end
            check($sformatf("frame_not_aborted dut%0d data %0h", m, e.data), e.abort, 0);
            check($sformatf("tx_bits dut%0d data %0h first_bad_cycle %0d", m, e.data, first_bad), bad_tx, 0);
            check($sformatf("busy_in_frame dut%0d data %0h low_cycles", m, e.data), bad_busy, 0);
            check($sformatf("done_in_frame dut%0d data %0h high_cycles", m, e.data), bad_done, 0);
            @(negedge clk);
            sample(m, t, b, d);
            check($sformatf("done_pulse dut%0d data %0h", m, e.data), d, 1);
            if (t === 1'b0) begin
                check($sformatf("busy_back_to_back dut%0d", m), b, 1);
                carry = 1;
            end else begin
                check($sformatf("busy_after_frame dut%0d data %0h", m, e.data), b, 0);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic request(input int m, input logic [7:0] d);
        @(negedge clk);
        if (m == 0) begin wr_a = 1'b1; data_a = d; end
        else        begin wr_b = 1'b1; data_b = d; end
        @(posedge clk);
        #1;
        if (m == 0) wr_a = 1'b0;
        else        wr_b = 1'b0;
    endtask

    task automatic wait_idle(input int m);
        int n;
        logic t, b, d;
        n = 0;
        @(negedge clk);
        sample(m, t, b, d);
        while (b && n < 1000) begin
            @(negedge clk);
            sample(m, t, b, d);
            n++;
        end
        if (n >= 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout dut%0d: busy still %0b after %0d cycles", m, b, n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ret = 1'b0; wr_a = 1'b0; wr_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
        repeat (3) @(negedge clk);
        check("reset tx_a", tx_a, 1);
        check("reset busy_a", busy_a, 0);
        check("reset done_a", done_a, 0);
        check("reset tx_b", tx_b, 1);
        check("reset busy_b", busy_b, 0);
        check("reset done_b", done_b, 0);
        ret = 1'b1;

        // 0xA5 on the 4-clock instance and 0x00 on the 2-clock instance together
        q_a.push_back('{8'hA5, 1'b0, 1'b0});
        q_b.push_back('{8'h00, 1'b0, 1'b0});
        @(negedge clk);
        wr_a = 1'b1; data_a = 8'hA5;
        wr_b = 1'b1; data_b = 8'h00;
        @(posedge clk);
        #1;
        wr_a = 1'b0; wr_b = 1'b0;
        data_a = 8'hFF;
        repeat (10) @(negedge clk);
        wr_a = 1'b1; data_a = 8'h11;
        @(posedge clk);
        #1;
        wr_a = 1'b0;
        wait_idle(0);
        wait_idle(1);

        q_a.push_back('{8'h07, 1'b1, 1'b0});
        request(0, 8'h07);
        wait_idle(0);

        // wr held high with a different byte: second frame must follow with no gap
        q_a.push_back('{8'h5A, 1'b0, 1'b0});
        q_a.push_back('{8'h3C, 1'b0, 1'b0});
        @(negedge clk);
        wr_a = 1'b1; data_a = 8'h5A;
        @(posedge clk);
        #1;
        data_a = 8'h3C;
        n = 0;
        @(negedge clk);
        while (done_a !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen_for_5A", (n < 1000), 1);
        wr_a = 1'b0;
        wait_idle(0);

        // reset during data bit 3 of a frame
        q_a.push_back('{8'h33, 1'b0, 1'b1});
        request(0, 8'h33);
        repeat (17) @(posedge clk);
        #1;
        ret = 1'b0;
        #1;
        check("abort tx_a", tx_a, 1);
        check("abort busy_a", busy_a, 0);
        check("abort done_a", done_a, 0);
        repeat (2) @(negedge clk);
        ret = 1'b1;

        q_a.push_back('{8'hFF, 1'b0, 1'b0});
        request(0, 8'hFF);
        wait_idle(0);

        q_b.push_back('{8'hC3, 1'b0, 1'b0});
        request(1, 8'hC3);
        wait_idle(1);

        repeat (4) @(negedge clk);
        check("queue_a_empty", q_a.size(), 0);
        check("queue_b_empty", q_b.size(), 0);
        check("done_while_idle", idle_done_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
